cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Responder end of the functional-unit completion handshake.
- Collects the registered FU_OUT_PACKET from every functional unit (ALU, mult, load, branch) and grants one per cycle to the Common Data Bus.
- Returns a one-cycle `ack` to the granted FU; broadcasts the winning packet, registered, to the ROB, RS and map table.
- Round-robin arbitration guarantees that no FU holding a done result starves.

Parameters:
- NUM_FU, 4, number of functional units competing for the CDB (≥2).
- IDX_W, $clog2(NUM_FU), width of the grant index.

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- fu_out_packets  input  NUM_FU x FU_OUT_PACKET  registered FU results. Entry i is requesting when its .done = 1.
- squash  input  1  mispredict flush from retire, synchronous.
- ack  output  NUM_FU  combinational per-FU acknowledge; at most one bit high, except during squash.
- cdb_packet  output  FU_OUT_PACKET  registered broadcast packet.
- cdb_valid  output  1  cdb_packet is valid this cycle.
- cdb_grant_idx  output  IDX_W  FU index that sourced cdb_packet (debug/perf).

Behaviour:
- Reset (reset==0, asynchronous): cdb_packet='0, cdb_valid=0, cdb_grant_idx=0, rr_ptr=0. `ack` is forced to 0 while reset is low. Reset asserted mid-transfer drops the in-flight broadcast; the FU is not acked, keeps its packet, and re-requests after reset.
- State:
  - rr_ptr (IDX_W): highest-priority FU for the next arbitration.
  - cdb_packet/cdb_valid/cdb_grant_idx output register.
- Request: req[i] = fu_out_packets[i].done.
- Arbitration (combinational):
  - Scan i = rr_ptr, rr_ptr+1, … mod NUM_FU; the first i with req[i]=1 wins.
  - No requester: no grant.
- ack: ack[win]=1 in the same cycle the request is seen. The FU samples ack at the same posedge, then clears or reloads its register. ack is never asserted to an FU with done=0.
- Broadcast (latency 1):
  - At the posedge with a grant: cdb_packet<=fu_out_packets[win], cdb_valid<=1, cdb_grant_idx<=win, rr_ptr<=(win+1) mod NUM_FU. NUM_FU-1 wraps to 0.
  - No grant: cdb_valid<=0, cdb_packet<='0; rr_ptr and cdb_grant_idx hold.
- Fairness: a continuously requesting FU is granted within NUM_FU cycles.
- Back-to-back: an FU acked at cycle t that reloads a new done packet at t+1 may request again at t+1. It wins only if it is the first requester from rr_ptr.
- Squash (overrides arbitration):
  - ack[i]=req[i] for all i, so every done FU is drained/cleared.
  - cdb_valid<=0, cdb_packet<='0, rr_ptr<=0.
  - A packet already in the cdb register at the squash cycle is still presented that cycle; the consumer ignores it under squash.
- Packet contents: all FU_OUT_PACKET fields pass unmodified (v, rob_tag, take_branch, branch_loc, mispredicted, origin_PC, cond_br_en, br_en). No width conversion.
- No latches: default assignments for ack and the winner index in the combinational logic.

Test Plan:
- Reset: hold reset=0 with all FUs done=1 → ack=0000, cdb_valid=0, cdb_packet=0. Release at cycle 3 → cycle 3 ack=0001; cycle 4 cdb_valid=1, cdb_grant_idx=0.
- Single requester: FU2 done with rob_tag=5, v=32'h0000_00AA → same-cycle ack=0100; next cycle cdb_valid=1, cdb_packet.rob_tag=5, v=32'hAA, cdb_grant_idx=2. FU2 done then dropped → following cycle cdb_valid=0.
- Round-robin: FUs 0–3 all held done=1 and reloaded after each ack → grants 0,1,2,3,0 on consecutive cycles. Each ack is one-hot; no FU waits more than 4 cycles.
- Wrap/skip: rr_ptr=3, requesters FU1 and FU3 → FU3 granted, rr_ptr→0. Next cycle only FU1 requests → FU1 granted, rr_ptr→2.
- Squash: FU0, FU2 done, squash=1 → ack=0101 in that cycle. Next cycle cdb_valid=0 and rr_ptr=0. FU1 done the following cycle → ack=0010.
- Mid-operation reset: grant issued to FU1 (ack=0010) and reset dropped before the posedge → cdb_valid=0 asynchronously and ack=0. FU1 keeps done=1 and is acked first after release.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdb_arbiter: round-robin grant of FU completion packets onto the CDB.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+

package cdb_pkg;
  typedef struct packed {
    logic [31:0] v;
    logic [4:0]  rob_tag;
    logic        take_branch;
    logic [31:0] branch_loc;
    logic        mispredicted;
    logic [31:0] origin_PC;
    logic        cond_br_en;
    logic        br_en;
    logic        done;
  } FU_OUT_PACKET;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int IDX_W  = $clog2(NUM_FU)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  FU_OUT_PACKET [NUM_FU-1:0]        fu_out_packets,
  input  logic                             squash,
  output logic [NUM_FU-1:0]                ack,
  output FU_OUT_PACKET                     cdb_packet,
  output logic                             cdb_valid,
  output logic [IDX_W-1:0]                 cdb_grant_idx
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_FU - 1);

  logic [NUM_FU-1:0] w_req;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  w_win;
  logic [IDX_W-1:0]  w_scan_idx;
  logic              w_grant;
  logic [IDX_W-1:0]  w_next_ptr;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_req
    assign w_req[gi] = fu_out_packets[gi].done;
  end

  // Scan from rr_ptr upward (modulo NUM_FU); the first requester wins.
  always_comb begin
    w_grant    = 1'b0;
    w_win      = '0;
    w_scan_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_scan_idx = IDX_W'((32'(r_rr_ptr) + 32'(k)) % 32'(NUM_FU));
      if (!w_grant && w_req[w_scan_idx]) begin
        w_grant = 1'b1;
        w_win   = w_scan_idx;
      end
    end
  end

  assign w_next_ptr = (w_win == c_last_idx) ? '0 : w_win + 1'b1;

  // Squash drains every done FU at once so nothing stale survives the flush.
  always_comb begin
    ack = '0;
    if (reset) begin
      if (squash) begin
        ack = w_req;
      end else if (w_grant) begin
        ack[w_win] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_packet    <= '0;
      cdb_valid     <= 1'b0;
      cdb_grant_idx <= '0;
      r_rr_ptr      <= '0;
    end else if (squash) begin
      cdb_packet    <= '0;
      cdb_valid     <= 1'b0;
      r_rr_ptr      <= '0;
    end else if (w_grant) begin
      cdb_packet    <= fu_out_packets[w_win];
      cdb_valid     <= 1'b1;
      cdb_grant_idx <= w_win;
      r_rr_ptr      <= w_next_ptr;
    end else begin
      cdb_packet    <= '0;
      cdb_valid     <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// Directed testbench for cdb_arbiter with 4 functional units.

module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic                    clock;
  logic                    reset;
  FU_OUT_PACKET [3:0]      fu;
  logic                    squash;
  logic [3:0]              ack;
  FU_OUT_PACKET            cdb_packet;
  logic                    cdb_valid;
  logic [1:0]              cdb_grant_idx;

  int checks;
  int failures;

  cdb_arbiter #(.NUM_FU(4), .IDX_W(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .fu_out_packets (fu),
    .squash         (squash),
    .ack            (ack),
    .cdb_packet     (cdb_packet),
    .cdb_valid      (cdb_valid),
    .cdb_grant_idx  (cdb_grant_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic FU_OUT_PACKET mk(input logic [31:0] v, input logic [4:0] tag);
    FU_OUT_PACKET p;
    p.v            = v;
    p.rob_tag      = tag;
    p.take_branch  = tag[0];
    p.branch_loc   = v + 32'd4;
    p.mispredicted = tag[1];
    p.origin_PC    = v ^ 32'h8000_0000;
    p.cond_br_en   = tag[2];
    p.br_en        = tag[3];
    p.done         = 1'b1;
    return p;
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset  = 1'b0;
    squash = 1'b0;
    fu     = '0;
    step;
    step;
    reset  = 1'b1;
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    squash = 1'b0;
    for (int i = 0; i < 4; i++) fu[i] = mk(32'h100 + 32'(i), 5'(i + 1));
    step;
    step;
    checks++;
    if (ack !== 4'b0000) begin
      failures++; $display("FAIL reset_ack: got %b expected 0000", ack);
    end
    checks++;
    if (cdb_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b expected 0", cdb_valid);
    end
    checks++;
    if (cdb_packet !== '0 || cdb_grant_idx !== 2'd0) begin
      failures++; $display("FAIL reset_packet: got %h idx %0d expected 0 idx 0", cdb_packet, cdb_grant_idx);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0001) begin
      failures++; $display("FAIL reset_release_ack: got %b expected 0001", ack);
    end
    step;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_grant_idx !== 2'd0 || cdb_packet !== mk(32'h100, 5'd1)) begin
      failures++; $display("FAIL reset_release_bcast: valid %b idx %0d pkt %h expected 1 0 %h",
                           cdb_valid, cdb_grant_idx, cdb_packet, mk(32'h100, 5'd1));
    end
    fu = '0;
  endtask

  task automatic test_single;
    do_reset;
    fu[2] = mk(32'h0000_00AA, 5'd5);
    #1;
    checks++;
    if (ack !== 4'b0100) begin
      failures++; $display("FAIL single_ack: got %b expected 0100", ack);
    end
    step;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_grant_idx !== 2'd2 || cdb_packet.rob_tag !== 5'd5 ||
        cdb_packet.v !== 32'hAA || cdb_packet !== mk(32'hAA, 5'd5)) begin
      failures++; $display("FAIL single_bcast: valid %b idx %0d pkt %h expected 1 2 %h",
                           cdb_valid, cdb_grant_idx, cdb_packet, mk(32'hAA, 5'd5));
    end
    fu[2] = '0;
    #1;
    checks++;
    if (ack !== 4'b0000) begin
      failures++; $display("FAIL single_idle_ack: got %b expected 0000", ack);
    end
    step;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_packet !== '0 || cdb_grant_idx !== 2'd2) begin
      failures++; $display("FAIL single_idle: valid %b pkt %h idx %0d expected 0 0 2",
                           cdb_valid, cdb_packet, cdb_grant_idx);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0]   exp_ack;
    FU_OUT_PACKET exp_pkt;
    int           exp;
    do_reset;
    for (int i = 0; i < 4; i++) fu[i] = mk(32'h200 + 32'(i), 5'(8 + i));
    for (int c = 0; c < 5; c++) begin
      exp     = c % 4;
      exp_ack = 4'b0001 << exp;
      exp_pkt = fu[exp];
      #1;
      checks++;
      if (ack !== exp_ack) begin
        failures++; $display("FAIL rr_ack[%0d]: got %b expected %b", c, ack, exp_ack);
      end
      step;
      checks++;
      if (cdb_valid !== 1'b1 || cdb_grant_idx !== 2'(exp) || cdb_packet !== exp_pkt) begin
        failures++; $display("FAIL rr_bcast[%0d]: valid %b idx %0d pkt %h expected 1 %0d %h",
                             c, cdb_valid, cdb_grant_idx, cdb_packet, exp, exp_pkt);
      end
      fu[exp] = mk(32'h300 + 32'(c), 5'(16 + c));
    end
  endtask

  task automatic test_wrap_skip;
    do_reset;
    fu[2] = mk(32'h400, 5'd2);
    step;
    fu    = '0;
    fu[1] = mk(32'h411, 5'd11);
    fu[3] = mk(32'h433, 5'd13);
    #1;
    checks++;
    if (ack !== 4'b1000) begin
      failures++; $display("FAIL wrap_ack: got %b expected 1000", ack);
    end
    step;
    checks++;
    if (cdb_grant_idx !== 2'd3 || cdb_packet !== mk(32'h433, 5'd13)) begin
      failures++; $display("FAIL wrap_bcast: idx %0d pkt %h expected 3 %h", cdb_grant_idx, cdb_packet, mk(32'h433, 5'd13));
    end
    fu[3] = '0;
    #1;
    checks++;
    if (ack !== 4'b0010) begin
      failures++; $display("FAIL skip_ack: got %b expected 0010", ack);
    end
    step;
    checks++;
    if (cdb_grant_idx !== 2'd1 || cdb_valid !== 1'b1) begin
      failures++; $display("FAIL skip_bcast: idx %0d valid %b expected 1 1", cdb_grant_idx, cdb_valid);
    end
    fu[1] = mk(32'h511, 5'd21);
    fu[2] = mk(32'h522, 5'd22);
    #1;
    checks++;
    if (ack !== 4'b0100) begin
      failures++; $display("FAIL skip_ptr_ack: got %b expected 0100", ack);
    end
  endtask

  task automatic test_squash;
    do_reset;
    fu[0] = mk(32'h600, 5'd6);
    step;
    fu[0] = mk(32'h601, 5'd7);
    fu[2] = mk(32'h622, 5'd8);
    squash = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0101) begin
      failures++; $display("FAIL squash_ack: got %b expected 0101", ack);
    end
    checks++;
    if (cdb_valid !== 1'b1 || cdb_packet !== mk(32'h600, 5'd6)) begin
      failures++; $display("FAIL squash_present: valid %b pkt %h expected 1 %h", cdb_valid, cdb_packet, mk(32'h600, 5'd6));
    end
    step;
    squash = 1'b0;
    fu     = '0;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_packet !== '0) begin
      failures++; $display("FAIL squash_clear: valid %b pkt %h expected 0 0", cdb_valid, cdb_packet);
    end
    fu[0] = mk(32'h700, 5'd9);
    fu[3] = mk(32'h733, 5'd10);
    #1;
    checks++;
    if (ack !== 4'b0001) begin
      failures++; $display("FAIL squash_ptr_ack: got %b expected 0001", ack);
    end
    fu    = '0;
    fu[1] = mk(32'h711, 5'd12);
    #1;
    checks++;
    if (ack !== 4'b0010) begin
      failures++; $display("FAIL squash_after_ack: got %b expected 0010", ack);
    end
    step;
    fu = '0;
  endtask

  task automatic test_mid_reset;
    do_reset;
    fu[0] = mk(32'h800, 5'd14);
    step;
    fu[0] = '0;
    fu[1] = mk(32'h811, 5'd15);
    #1;
    checks++;
    if (ack !== 4'b0010 || cdb_valid !== 1'b1) begin
      failures++; $display("FAIL midrst_pre: ack %b valid %b expected 0010 1", ack, cdb_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (ack !== 4'b0000 || cdb_valid !== 1'b0 || cdb_packet !== '0) begin
      failures++; $display("FAIL midrst_async: ack %b valid %b pkt %h expected 0000 0 0", ack, cdb_valid, cdb_packet);
    end
    step;
    reset = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0010) begin
      failures++; $display("FAIL midrst_release_ack: got %b expected 0010", ack);
    end
    step;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_grant_idx !== 2'd1 || cdb_packet !== mk(32'h811, 5'd15)) begin
      failures++; $display("FAIL midrst_bcast: valid %b idx %0d pkt %h expected 1 1 %h",
                           cdb_valid, cdb_grant_idx, cdb_packet, mk(32'h811, 5'd15));
    end
    fu = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    squash   = 1'b0;
    fu       = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_wrap_skip;
    test_squash;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
